// File: rtl/oam_dma_ctrl.sv
// OAM DMA sequencer: captures writes to $FF46, waits a fixed setup delay, then
// copies BYTES bytes from the selected page into OAM, one byte per CYC_PER_BYTE clocks.
module oam_dma_ctrl #(
  parameter int unsigned BYTES        = 160,
  parameter int unsigned CYC_PER_BYTE = 4,
  parameter int unsigned SETUP_CYC    = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] cpu_addr,
  input  logic        cpu_wr,
  input  logic [7:0]  cpu_wdata,
  output logic [7:0]  ff46_q,
  output logic        busy,
  output logic        done,
  output logic [15:0] src_addr,
  output logic        src_vram,
  output logic        src_rd,
  input  logic [7:0]  ext_data,
  input  logic [7:0]  vram_data,
  output logic [7:0]  oam_addr,
  output logic [7:0]  oam_wdata,
  output logic        oam_we
);

  localparam int unsigned TOTAL_CYC = BYTES * CYC_PER_BYTE;
  localparam int unsigned CNT_W     = $clog2(TOTAL_CYC);
  localparam int unsigned SUB_W     = $clog2(CYC_PER_BYTE);
  localparam int unsigned SCNT_W    = (SETUP_CYC > 1) ? $clog2(SETUP_CYC) : 1;

  localparam logic [15:0]       DMA_REG_ADDR = 16'hFF46;
  localparam logic [CNT_W-1:0]  CNT_LAST     = CNT_W'(TOTAL_CYC - 1);
  localparam logic [SCNT_W-1:0] SCNT_LAST    = SCNT_W'(SETUP_CYC - 1);
  localparam logic [SUB_W-1:0]  SUB_LAST     = SUB_W'(CYC_PER_BYTE - 1);
  localparam logic [7:0]        ECHO_PAGE    = 8'hE0;
  localparam logic [7:0]        ECHO_OFS     = 8'h20;

  typedef enum logic {
    S_IDLE   = 1'b0,
    S_ACTIVE = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [7:0]          ff46_d;
  logic                pend_q, pend_d;
  logic [SCNT_W-1:0]   scnt_q, scnt_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [7:0]          page_q, page_d;
  logic                done_d;

  logic                reg_wr_c;
  logic                setup_exp_c;
  logic [7:0]          idx_c;
  logic [SUB_W-1:0]    sub_c;
  logic [7:0]          base_page_c;
  logic [15:0]         act_addr_c;
  logic                act_vram_c;

  // Register write decode; a fresh write always re-arms the setup and so blocks a same-cycle expiry
  assign reg_wr_c    = cpu_wr && (cpu_addr == DMA_REG_ADDR);
  assign setup_exp_c = pend_q && !reg_wr_c && (scnt_q == SCNT_LAST);

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      ff46_q  <= 8'h00;
      pend_q  <= 1'b0;
      scnt_q  <= '0;
      cnt_q   <= '0;
      page_q  <= 8'h00;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      ff46_q  <= ff46_d;
      pend_q  <= pend_d;
      scnt_q  <= scnt_d;
      cnt_q   <= cnt_d;
      page_q  <= page_d;
      done    <= done_d;
    end
  end

  // Next-state: register capture, setup countdown, transfer counter
  always_comb begin
    state_d = state_q;
    ff46_d  = ff46_q;
    pend_d  = pend_q;
    scnt_d  = scnt_q;
    cnt_d   = cnt_q;
    page_d  = page_q;
    done_d  = 1'b0;

    if (reg_wr_c) begin
      ff46_d = cpu_wdata;
      pend_d = 1'b1;
      scnt_d = '0;
    end else if (pend_q) begin
      if (setup_exp_c) begin
        pend_d = 1'b0;
        scnt_d = '0;
      end else begin
        scnt_d = scnt_q + SCNT_W'(1);
      end
    end

    case (state_q)
      S_IDLE: begin
        if (setup_exp_c) begin
          state_d = S_ACTIVE;
          cnt_d   = '0;
          page_d  = ff46_q;
        end
      end
      S_ACTIVE: begin
        // A matured rewrite restarts the copy and suppresses done for the abandoned one
        if (setup_exp_c) begin
          cnt_d  = '0;
          page_d = ff46_q;
        end else if (cnt_q == CNT_LAST) begin
          state_d = S_IDLE;
          cnt_d   = '0;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Transfer address and source decode from the current page and counter
  always_comb begin
    idx_c       = 8'(cnt_q >> SUB_W);
    sub_c       = cnt_q[SUB_W-1:0];
    base_page_c = (page_q >= ECHO_PAGE) ? (page_q - ECHO_OFS) : page_q;
    act_addr_c  = {base_page_c, 8'h00} + {8'h00, idx_c};
    act_vram_c  = (act_addr_c[15:13] == 3'b100);
  end

  assign busy = (state_q == S_ACTIVE);

  // Bus-facing outputs, forced to zero while idle
  always_comb begin
    src_addr  = 16'h0000;
    src_vram  = 1'b0;
    src_rd    = 1'b0;
    oam_addr  = 8'h00;
    oam_wdata = 8'h00;
    oam_we    = 1'b0;
    if (busy) begin
      src_addr  = act_addr_c;
      src_vram  = act_vram_c;
      src_rd    = 1'b1;
      oam_addr  = idx_c;
      oam_wdata = act_vram_c ? vram_data : ext_data;
      oam_we    = (sub_c == SUB_LAST);
    end
  end

endmodule

// File: tb/tb_oam_dma_ctrl.sv
// Randomised and directed bench for oam_dma_ctrl against a cycle-numbered transfer model.
module tb_oam_dma_ctrl;

  localparam int BYTES = 160;
  localparam int CPB   = 4;
  localparam int SETUP = 4;
  localparam int TOTAL = BYTES * CPB;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] cpu_addr;
  logic        cpu_wr;
  logic [7:0]  cpu_wdata;
  logic [7:0]  ff46_q;
  logic        busy, done;
  logic [15:0] src_addr;
  logic        src_vram, src_rd;
  logic [7:0]  ext_data, vram_data;
  logic [7:0]  oam_addr, oam_wdata;
  logic        oam_we;

  always #5 clk = ~clk;

  oam_dma_ctrl #(.BYTES(BYTES), .CYC_PER_BYTE(CPB), .SETUP_CYC(SETUP)) dut (
    .clk(clk), .rst(rst), .cpu_addr(cpu_addr), .cpu_wr(cpu_wr), .cpu_wdata(cpu_wdata),
    .ff46_q(ff46_q), .busy(busy), .done(done), .src_addr(src_addr), .src_vram(src_vram),
    .src_rd(src_rd), .ext_data(ext_data), .vram_data(vram_data), .oam_addr(oam_addr),
    .oam_wdata(oam_wdata), .oam_we(oam_we)
  );

  int n_vec = 0;
  int n_err = 0;

  // Model: cycle numbers of the pending restart, the current transfer start and the done pulse
  int         cyc = 0;
  int         restart_at = -1;
  int         start = -1;
  int         done_at = -1;
  logic [7:0] m_ff46 = 8'h00;
  logic [7:0] m_page = 8'h00;
  bit         mvalid = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [15:0] exp_src();
    int k, pg;
    if (start < 0) return 16'h0000;
    k  = cyc - start;
    pg = (m_page >= 8'hE0) ? int'(m_page) - 32 : int'(m_page);
    return 16'((pg * 256 + k / CPB) % 65536);
  endfunction

  // Model update from the inputs sampled at this edge
  always @(posedge clk) begin
    if (!rst) begin
      m_ff46 = 8'h00; m_page = 8'h00;
      restart_at = -1; start = -1; done_at = -1;
      mvalid = 1'b1;
    end else if (cpu_wr && cpu_addr == 16'hFF46) begin
      m_ff46     = cpu_wdata;
      restart_at = cyc + 1 + SETUP;
    end
    cyc++;
    if (restart_at == cyc) begin
      start = cyc; m_page = m_ff46; restart_at = -1;
    end else if (start >= 0 && cyc == start + TOTAL) begin
      start = -1; done_at = cyc;
    end
  end

  // Per-cycle compare of every output against the model
  always @(negedge clk) begin
    bit b; int k; logic [15:0] a; bit v;
    if (mvalid) begin
      b = (start >= 0);
      k = b ? cyc - start : 0;
      a = exp_src();
      v = b && (a >= 16'h8000) && (a <= 16'h9FFF);
      chk("busy", busy, b);
      chk("done", done, done_at == cyc);
      chk("ff46_q", ff46_q, m_ff46);
      chk("src_addr", src_addr, a);
      chk("src_vram", src_vram, v);
      chk("src_rd", src_rd, b);
      chk("oam_addr", oam_addr, b ? k / CPB : 0);
      chk("oam_we", oam_we, b && (k % CPB == CPB - 1));
      chk("oam_wdata", oam_wdata, !b ? 32'h0 : (v ? 32'(vram_data) : 32'(ext_data)));
    end
  end

  // Directed-test observation statistics
  bit         follow_src = 1'b0;
  bit         use_vfix = 1'b0;
  logic [7:0] vram_fix = 8'h00;
  int first_busy, last_busy, busy_cnt, vram_cnt, we_cnt, w5a, done_cnt, done_cyc;
  int probe_cyc, after_cyc, we_after;
  logic [15:0] first_src, last_src, probe_src;
  logic [7:0]  probe_ff46;
  bit          probe_nz;
  logic [7:0]  img [BYTES];

  task automatic clear_stats();
    first_busy = -1; last_busy = -1; busy_cnt = 0; vram_cnt = 0; we_cnt = 0; w5a = 0;
    done_cnt = 0; done_cyc = -1; probe_cyc = -1; after_cyc = 1 << 30; we_after = 0;
    first_src = 16'hDEAD; last_src = 16'hDEAD; probe_src = 16'hDEAD;
    probe_ff46 = 8'hEE; probe_nz = 1'b1;
    for (int n = 0; n < BYTES; n++) img[n] = ~8'(n);
  endtask

  task automatic observe();
    if (busy) begin
      if (first_busy < 0) begin first_busy = cyc; first_src = src_addr; end
      last_busy = cyc; last_src = src_addr; busy_cnt++;
      if (src_vram) vram_cnt++;
    end
    if (oam_we) begin
      we_cnt++;
      if (oam_addr < 8'(BYTES)) img[oam_addr] = oam_wdata;
      if (oam_wdata == 8'h5A) w5a++;
      if (cyc > after_cyc) we_after++;
    end
    if (done) begin done_cnt++; done_cyc = cyc; end
    if (cyc == probe_cyc) begin
      probe_src  = src_addr;
      probe_ff46 = ff46_q;
      probe_nz   = |{busy, done, ff46_q, src_addr, src_vram, src_rd, oam_addr, oam_wdata, oam_we};
    end
  endtask

  // One clock of stimulus; entered and left #1 after a rising edge
  task automatic step(input logic r, input logic wr, input logic [15:0] a, input logic [7:0] d);
    logic [15:0] s;
    s = exp_src();
    rst = r; cpu_wr = wr; cpu_addr = a; cpu_wdata = d;
    ext_data  = follow_src ? s[7:0] : 8'($urandom);
    vram_data = use_vfix ? vram_fix : 8'($urandom);
    @(negedge clk);
    observe();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b1, 1'b0, 16'($urandom), 8'($urandom));
  endtask

  task automatic wr46(input logic [7:0] d);
    step(1'b1, 1'b1, 16'hFF46, d);
  endtask

  initial begin
    int w1, w2, bad, r;
    rst = 1'b0; cpu_wr = 1'b0; cpu_addr = 16'h0; cpu_wdata = 8'h0;
    ext_data = 8'h0; vram_data = 8'h0;
    clear_stats();
    @(posedge clk); #1;
    repeat (3) step(1'b0, 1'b0, 16'h0, 8'h0);
    chk("reset_busy", busy, 0);
    chk("reset_ff46", ff46_q, 0);
    chk("reset_src_addr", src_addr, 0);

    // Basic WRAM transfer, ext_data mirrors the source address low byte
    clear_stats(); follow_src = 1'b1; w1 = cyc;
    wr46(8'hC1); idle(660); follow_src = 1'b0;
    chk("basic_busy_start", first_busy - w1, 5);
    chk("basic_busy_end", last_busy - w1, 644);
    chk("basic_busy_len", busy_cnt, 640);
    chk("basic_done_cycle", done_cyc - w1, 645);
    chk("basic_done_count", done_cnt, 1);
    chk("basic_we_count", we_cnt, 160);
    chk("basic_last_src", last_src, 16'hC19F);
    chk("basic_vram_cycles", vram_cnt, 0);
    bad = 0;
    for (int n = 0; n < BYTES; n++) if (img[n] !== 8'(n)) bad++;
    chk("basic_oam_image", bad, 0);

    // VRAM source
    clear_stats(); use_vfix = 1'b1; vram_fix = 8'h5A;
    wr46(8'h80); idle(660); use_vfix = 1'b0;
    chk("vram_first_src", first_src, 16'h8000);
    chk("vram_last_src", last_src, 16'h809F);
    chk("vram_cycles", vram_cnt, 640);
    chk("vram_5a_writes", w5a, 160);

    // Echo-RAM alias
    clear_stats();
    wr46(8'hE0); idle(660);
    chk("echo_first_src", first_src, 16'hC000);
    chk("echo_last_src", last_src, 16'hC09F);

    // Rewrite at busy-cycle 100
    clear_stats(); w1 = cyc;
    wr46(8'hC0);
    while (cyc < w1 + 5 + 100) idle(1);
    w2 = cyc; probe_cyc = w2 + 5;
    wr46(8'hD0); idle(700);
    chk("rewrite_busy_len", busy_cnt, 745);
    chk("rewrite_busy_end", last_busy - w2, 644);
    chk("rewrite_done_count", done_cnt, 1);
    chk("rewrite_done_cycle", done_cyc - w2, 645);
    chk("rewrite_restart_src", probe_src, 16'hD000);

    // Rewrite whose setup matures on the final byte cycle
    clear_stats(); w1 = cyc;
    wr46(8'hC2);
    while (cyc < w1 + 640) idle(1);
    wr46(8'hC3); idle(700);
    chk("coincide_busy_len", busy_cnt, 1280);
    chk("coincide_done_count", done_cnt, 1);
    chk("coincide_done_cycle", done_cyc - w1, 1285);

    // Reset at busy-cycle 300
    clear_stats(); w1 = cyc;
    wr46(8'hC1);
    while (cyc < w1 + 5 + 300) idle(1);
    probe_cyc = cyc + 1; after_cyc = cyc;
    step(1'b0, 1'b0, 16'h0, 8'h0); idle(700);
    chk("midreset_outputs_nonzero", probe_nz, 0);
    chk("midreset_ff46", probe_ff46, 8'h00);
    chk("midreset_done_count", done_cnt, 0);
    chk("midreset_we_after", we_after, 0);
    chk("midreset_we_count", we_cnt, 75);

    // Neighbouring registers and readback
    clear_stats();
    step(1'b1, 1'b1, 16'hFF45, 8'h12); idle(3);
    step(1'b1, 1'b1, 16'hFF47, 8'h34); idle(20);
    chk("nomatch_busy", busy_cnt, 0);
    chk("nomatch_ff46", ff46_q, 8'h00);
    wr46(8'h9F); idle(700);
    chk("readback_ff46", ff46_q, 8'h9F);
    chk("readback_first_src", first_src, 16'h9F00);

    // Random traffic: sparse transfers, then dense rewrites during setup
    for (int i = 0; i < 2500; i++) begin
      r = $urandom_range(0, 999);
      if (r == 0)      step(1'b0, 1'($urandom), 16'hFF46, 8'($urandom));
      else if (r < 4)  wr46(8'($urandom));
      else if (r < 40) step(1'b1, 1'b1, 16'($urandom), 8'($urandom));
      else             idle(1);
    end
    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(0, 7);
      if (r < 2) wr46(8'($urandom));
      else       idle(1);
    end
    idle(700);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #3_000_000;
    n_err++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
